// File: rtl/sram_read_sense.sv
// SRAM column read sequencer: precharge, wordline develop, sense, resolve.
// Optional margin check enabled by defining SRAM_READ_MARGIN_CHK_EN.
module sram_read_sense #(
    parameter int  PRE_CYCLES   = 2,
    parameter int  DEV_CYCLES   = 3,
    parameter real SENSE_MARGIN = 0.1,
    parameter real VDD          = 1.5,
    parameter real VSS          = 0.0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_req,
    input  real  bl_rd,
    input  real  blb_rd,
    output logic pre_en,
    output logic wl_en,
    output logic sae,
    output logic busy,
    output real  data_out,
    output logic data_valid,
    output logic rd_err
);

    localparam int MAX_CYC = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] DEV_LAST = CW'(DEV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CYC);

    // Reject nonsensical configurations at elaboration time
    if (PRE_CYCLES < 1 || DEV_CYCLES < 1 || SENSE_MARGIN < 0.0) begin : g_bad_cfg
        $error("sram_read_sense: invalid parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        DEVELOP,
        SENSE,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   next_cnt;
    logic [CW-1:0]   cnt_inc;

    logic pre_d;
    logic wl_d;
    logic sae_d;
    logic busy_d;
    logic dv_d;

    real  diff;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    next_state = PRECHARGE;
                    next_cnt   = '0;
                end
            end
            PRECHARGE: begin
                if (cnt == PRE_LAST) begin
                    next_state = DEVELOP;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_inc;
                end
            end
            DEVELOP: begin
                if (cnt == DEV_LAST) begin
                    next_state = SENSE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_inc;
                end
            end
            SENSE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control decode from the current state
    always_comb begin
        pre_d  = (state == PRECHARGE);
        wl_d   = (state == DEVELOP) || (state == SENSE);
        sae_d  = (state == SENSE);
        busy_d = (state != IDLE);
        dv_d   = (state == DONE);
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_en     <= 1'b0;
            wl_en      <= 1'b0;
            sae        <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            pre_en     <= pre_d;
            wl_en      <= wl_d;
            sae        <= sae_d;
            busy       <= busy_d;
            data_valid <= dv_d;
        end
    end

    // Differential bitline voltage seen by the sense amp
    always_comb begin
        diff = bl_rd - blb_rd;
    end

`ifdef SRAM_READ_MARGIN_CHK_EN
    real  mag;
    logic err_q;

    // Magnitude of the bitline split
    always_comb begin
        mag = (diff < 0.0) ? -diff : diff;
    end

    // Resolve on leaving SENSE; a weak split keeps the old value and flags it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= VSS;
            err_q    <= 1'b0;
        end else if (state == SENSE) begin
            if (mag < SENSE_MARGIN) begin
                err_q <= 1'b1;
            end else begin
                err_q    <= 1'b0;
                data_out <= (diff > 0.0) ? VDD : VSS;
            end
        end
    end

    // Error pulse aligned with data_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err <= 1'b0;
        end else begin
            rd_err <= (state == DONE) && err_q;
        end
    end
`else
    // Resolve on the sign of the split when leaving SENSE; zero resolves low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= VSS;
        end else if (state == SENSE) begin
            data_out <= (diff > 0.0) ? VDD : VSS;
        end
    end

    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_read_sense.sv
// Directed bench for sram_read_sense: timing, resolution, reset abort.
// A second instance checks the short PRE_CYCLES=1/DEV_CYCLES=1 build.
module tb_sram_read_sense;

    logic clk;
    logic rst_n;
    logic rd_req;
    logic rd_req2;
    real  bl_rd;
    real  blb_rd;

    logic pre_en, wl_en, sae, busy, data_valid, rd_err;
    real  data_out;
    logic pre2, wl2, sae2, busy2, dv2, err2;
    real  dout2;

    int n_cmp;
    int n_fail;

    logic pre_a  [64];
    logic wl_a   [64];
    logic sae_a  [64];
    logic busy_a [64];
    logic dv_a   [64];
    logic err_a  [64];
    real  dout_a [64];

`ifdef SRAM_READ_MARGIN_CHK_EN
    localparam logic MCHK = 1'b1;
`else
    localparam logic MCHK = 1'b0;
`endif

    sram_read_sense dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .bl_rd      (bl_rd),
        .blb_rd     (blb_rd),
        .pre_en     (pre_en),
        .wl_en      (wl_en),
        .sae        (sae),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .rd_err     (rd_err)
    );

    sram_read_sense #(
        .PRE_CYCLES (1),
        .DEV_CYCLES (1)
    ) dut_short (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req2),
        .bl_rd      (bl_rd),
        .blb_rd     (blb_rd),
        .pre_en     (pre2),
        .wl_en      (wl2),
        .sae        (sae2),
        .busy       (busy2),
        .data_out   (dout2),
        .data_valid (dv2),
        .rd_err     (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request (held for 'hold' edges) and record n cycles of outputs.
    // Index i holds the values in the cycle after request edge N+i.
    task automatic capture(input real bl, input real blb, input int hold, input int n);
        @(negedge clk);
        bl_rd  = bl;
        blb_rd = blb;
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pre_a[i]  = pre_en;
            wl_a[i]   = wl_en;
            sae_a[i]  = sae;
            busy_a[i] = busy;
            dv_a[i]   = data_valid;
            err_a[i]  = rd_err;
            dout_a[i] = data_out;
            if (i + 1 >= hold) rd_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        int dv_seen;
        rst_n   = 1'b0;
        rd_req  = 1'b0;
        rd_req2 = 1'b0;
        bl_rd   = 0.0;
        blb_rd  = 0.0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({pre_en, wl_en, sae, busy, data_valid, rd_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {pre_en, wl_en, sae, busy, data_valid, rd_err});
        end
        n_cmp++;
        if (data_out != 0.0) begin
            n_fail++;
            $display("FAIL reset_dout: got %f want 0.0", data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(1.5, 0.2, 1, 10);
        n_cmp++;
        if (dout_a[9] != 1.5) begin
            n_fail++;
            $display("FAIL pre_abort_dout: got %f want 1.5", dout_a[9]);
        end
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wl_en !== 1'b1 || pre_en !== 1'b0) begin
            n_fail++;
            $display("FAIL in_develop: got wl=%b pre=%b want wl=1 pre=0", wl_en, pre_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pre_en, wl_en, sae, busy, data_valid, rd_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_ctrl: got %b want 000000",
                     {pre_en, wl_en, sae, busy, data_valid, rd_err});
        end
        n_cmp++;
        if (data_out != 0.0) begin
            n_fail++;
            $display("FAIL abort_dout: got %f want 0.0", data_out);
        end
        dv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
        end
        n_cmp++;
        if (dv_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_dv: got %0d pulses want 0", dv_seen);
        end
        capture(1.5, 0.2, 1, 10);
        n_cmp++;
        if (dv_a[6] !== 1'b0 || dv_a[7] !== 1'b1 || dout_a[7] != 1.5) begin
            n_fail++;
            $display("FAIL post_reset_read: got dv6=%b dv7=%b dout=%f want 0 1 1.5",
                     dv_a[6], dv_a[7], dout_a[7]);
        end
    endtask

    task automatic test_read_one;
        int np, nw, ns, nd, ne, bad;
        capture(1.5, 0.2, 1, 12);
        np = 0; nw = 0; ns = 0; nd = 0; ne = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            np += int'(pre_a[i]);
            nw += int'(wl_a[i]);
            ns += int'(sae_a[i]);
            nd += int'(dv_a[i]);
            ne += int'(err_a[i]);
            if ((pre_a[i] && wl_a[i]) || (sae_a[i] && !wl_a[i])) bad++;
        end
        n_cmp++;
        if (np !== 2 || pre_a[1] !== 1'b1 || pre_a[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_window: got count %0d want 2 at cycles 1-2", np);
        end
        n_cmp++;
        if (nw !== 4 || wl_a[3] !== 1'b1 || wl_a[6] !== 1'b1) begin
            n_fail++;
            $display("FAIL wl_window: got count %0d want 4 at cycles 3-6", nw);
        end
        n_cmp++;
        if (ns !== 1 || sae_a[6] !== 1'b1) begin
            n_fail++;
            $display("FAIL sae_window: got count %0d want 1 at cycle 6", ns);
        end
        n_cmp++;
        if (nd !== 1 || dv_a[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL dv_latency: got count %0d dv7=%b want 1 at cycle 7", nd, dv_a[7]);
        end
        n_cmp++;
        if (dout_a[7] != 1.5 || ne !== 0) begin
            n_fail++;
            $display("FAIL read_one: got dout=%f errs=%0d want 1.5 0", dout_a[7], ne);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL exclusivity: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_read_zero;
        int nd;
        capture(0.3, 1.4, 1, 12);
        nd = 0;
        for (int i = 0; i < 12; i++) nd += int'(dv_a[i]);
        n_cmp++;
        if (dout_a[5] != 1.5 || dout_a[6] != 0.0 || dout_a[7] != 0.0) begin
            n_fail++;
            $display("FAIL read_zero: got %f %f %f want 1.5 0.0 0.0",
                     dout_a[5], dout_a[6], dout_a[7]);
        end
        n_cmp++;
        if (nd !== 1 || dv_a[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_dv_pulse: got count %0d want 1", nd);
        end
        n_cmp++;
        if (busy_a[7] !== 1'b1 || busy_a[8] !== 1'b0 || busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: got b0=%b b7=%b b8=%b want 0 1 0",
                     busy_a[0], busy_a[7], busy_a[8]);
        end
    endtask

    task automatic test_back_to_back;
        int nd, bad;
        capture(1.5, 0.2, 30, 40);
        nd = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            nd += int'(dv_a[i]);
            if ((pre_a[i] && wl_a[i]) || (sae_a[i] && !wl_a[i])) bad++;
        end
        n_cmp++;
        if (nd !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d reads want 4", nd);
        end
        n_cmp++;
        if (dv_a[7] !== 1'b1 || dv_a[15] !== 1'b1 || dv_a[23] !== 1'b1 || dv_a[31] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %b%b%b%b want 1111 at 7/15/23/31",
                     dv_a[7], dv_a[15], dv_a[23], dv_a[31]);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_exclusive: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_margin;
        capture(1.5, 0.2, 1, 10);
        capture(0.80, 0.75, 1, 10);
        n_cmp++;
        if (dv_a[7] !== 1'b1 || err_a[7] !== MCHK || err_a[6] !== 1'b0 || err_a[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL margin_err: got dv=%b err=%b want 1 %b", dv_a[7], err_a[7], MCHK);
        end
        n_cmp++;
        if (dout_a[9] != 1.5) begin
            n_fail++;
            $display("FAIL margin_dout: got %f want 1.5", dout_a[9]);
        end
    endtask

    task automatic test_tie;
        real exp_d;
        exp_d = MCHK ? 1.5 : 0.0;
        capture(0.7, 0.7, 1, 10);
        n_cmp++;
        if (dout_a[7] != exp_d || err_a[7] !== MCHK) begin
            n_fail++;
            $display("FAIL tie: got dout=%f err=%b want %f %b",
                     dout_a[7], err_a[7], exp_d, MCHK);
        end
    endtask

    task automatic test_short;
        int np, nw, nd;
        np = 0; nw = 0; nd = 0;
        @(negedge clk);
        bl_rd   = 1.5;
        blb_rd  = 0.2;
        rd_req2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_req2 = 1'b0;
            np += int'(pre2);
            nw += int'(wl2);
            nd += int'(dv2);
            if (i == 3 && sae2 !== 1'b1) nd += 100;
            if (i == 4) begin
                n_cmp++;
                if (dv2 !== 1'b1 || dout2 != 1.5) begin
                    n_fail++;
                    $display("FAIL short_latency: got dv=%b dout=%f want 1 1.5", dv2, dout2);
                end
            end
        end
        n_cmp++;
        if (np !== 1 || nw !== 2 || nd !== 1) begin
            n_fail++;
            $display("FAIL short_windows: got pre=%0d wl=%0d dv=%0d want 1 2 1", np, nw, nd);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset;
        test_read_one;
        test_read_zero;
        test_back_to_back;
        test_margin;
        test_tie;
        test_short;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
